// File: rtl/fm_freq_demod.sv
// Polar-discriminator FM demodulator: o_data = I[n-1]*Q[n] - Q[n-1]*I[n], four register stages.
// Define FM_DEMOD_PRIME_EN to suppress the strobe of the first accept after reset.
module fm_freq_demod (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [15:0]        i_I_data,
  input  logic               i_I_valid,
  input  logic [15:0]        i_Q_data,
  input  logic               i_Q_valid,
  output logic signed [33:0] o_data,
  output logic               o_valid
);

  logic               acc_q, acc_d;
  logic [15:0]        in_i_q, in_i_d;
  logic [15:0]        in_q_q, in_q_d;

  logic [15:0]        i_prev_q, i_prev_d;
  logic [15:0]        q_prev_q, q_prev_d;

  logic signed [15:0] i_s1_q, i_s1_d;
  logic signed [15:0] q_s1_q, q_s1_d;
  logic signed [16:0] di_s1_q, di_s1_d;
  logic signed [16:0] dq_s1_q, dq_s1_d;
  logic               v_s1_q, v_s1_d;

  logic signed [32:0] p1_q, p1_d;
  logic signed [32:0] p2_q, p2_d;
  logic               v_s2_q, v_s2_d;

  logic signed [33:0] o_data_q, o_data_d;
  logic               o_valid_q, o_valid_d;

`ifdef FM_DEMOD_PRIME_EN
  logic               primed_q, primed_d;
`endif

  always_comb begin
    // Capture stage: only a cycle with both valids counts as an accept.
    acc_d  = i_I_valid & i_Q_valid;
    in_i_d = acc_d ? i_I_data : in_i_q;
    in_q_d = acc_d ? i_Q_data : in_q_q;

    i_prev_d = i_prev_q;
    q_prev_d = q_prev_q;
    i_s1_d   = i_s1_q;
    q_s1_d   = q_s1_q;
    di_s1_d  = di_s1_q;
    dq_s1_d  = dq_s1_q;
    if (acc_q) begin
      i_s1_d   = $signed(in_i_q);
      q_s1_d   = $signed(in_q_q);
      di_s1_d  = $signed({in_i_q[15], in_i_q}) - $signed({i_prev_q[15], i_prev_q});
      dq_s1_d  = $signed({in_q_q[15], in_q_q}) - $signed({q_prev_q[15], q_prev_q});
      i_prev_d = in_i_q;
      q_prev_d = in_q_q;
    end

`ifdef FM_DEMOD_PRIME_EN
    primed_d = primed_q | acc_q;
    v_s1_d   = acc_q & primed_q;
`else
    v_s1_d   = acc_q;
`endif

    p1_d   = p1_q;
    p2_d   = p2_q;
    if (v_s1_q) begin
      p1_d = i_s1_q * dq_s1_q;
      p2_d = q_s1_q * di_s1_q;
    end
    v_s2_d = v_s1_q;

    o_data_d  = o_data_q;
    if (v_s2_q) begin
      o_data_d = $signed({p1_q[32], p1_q}) - $signed({p2_q[32], p2_q});
    end
    o_valid_d = v_s2_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q     <= 1'b0;
      in_i_q    <= '0;
      in_q_q    <= '0;
      i_prev_q  <= '0;
      q_prev_q  <= '0;
      i_s1_q    <= '0;
      q_s1_q    <= '0;
      di_s1_q   <= '0;
      dq_s1_q   <= '0;
      v_s1_q    <= 1'b0;
      p1_q      <= '0;
      p2_q      <= '0;
      v_s2_q    <= 1'b0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
`ifdef FM_DEMOD_PRIME_EN
      primed_q  <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      in_i_q    <= in_i_d;
      in_q_q    <= in_q_d;
      i_prev_q  <= i_prev_d;
      q_prev_q  <= q_prev_d;
      i_s1_q    <= i_s1_d;
      q_s1_q    <= q_s1_d;
      di_s1_q   <= di_s1_d;
      dq_s1_q   <= dq_s1_d;
      v_s1_q    <= v_s1_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      v_s2_q    <= v_s2_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
`ifdef FM_DEMOD_PRIME_EN
      primed_q  <= primed_d;
`endif
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_fm_freq_demod.sv
// Randomized and directed bench for fm_freq_demod against a cross-product reference model.
module tb_fm_freq_demod;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_d = '0;
  logic [15:0] q_d = '0;
  logic        iv = 1'b0;
  logic        qv = 1'b0;
  logic signed [33:0] o_data;
  logic        o_valid;

  fm_freq_demod dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_I_data (i_d),
    .i_I_valid(iv),
    .i_Q_data (q_d),
    .i_Q_valid(qv),
    .o_data   (o_data),
    .o_valid  (o_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint prev_i, prev_q;
  bit     primed;
  longint exp_q[$];
  int     due_q[$];
  longint last_exp;
  int     cyc = 0;
  longint last_out;
  int     strobes;

`ifdef FM_DEMOD_PRIME_EN
  localparam int PAIR_STROBES = 1;
`else
  localparam int PAIR_STROBES = 2;
`endif

  task automatic model_reset();
    prev_i = 0;
    prev_q = 0;
    primed = 0;
    exp_q.delete();
    due_q.delete();
    last_exp = 0;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // One clock: update the reference on the edge, then compare outputs 1 time unit later.
  task automatic step();
    longint si, sq, e, od;
    @(posedge clk);
    cyc++;
    if (rst_n && iv && qv) begin
      si = longint'($signed(i_d));
      sq = longint'($signed(q_d));
      e  = prev_i * sq - prev_q * si;
      if (PAIR_STROBES == 2 || primed) begin
        exp_q.push_back(e);
        due_q.push_back(cyc + 3);
      end
      primed = 1;
      prev_i = si;
      prev_q = sq;
    end
    #1;
    od = longint'(o_data);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("o_valid_strobe", longint'(o_valid), 1);
      check("o_data_value", od, exp_q[0]);
      last_exp = exp_q[0];
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      check("o_valid_idle", longint'(o_valid), 0);
      check("o_data_hold", od, last_exp);
    end
    if (o_valid) begin
      strobes++;
      last_out = od;
    end
  endtask

  task automatic send(input int si, input int sq, input bit vi, input bit vq);
    i_d = 16'(si);
    q_d = 16'(sq);
    iv  = vi;
    qv  = vq;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send(0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_o_valid", longint'(o_valid), 0);
    check("reset_o_data", longint'(o_data), 0);
    model_reset();
    iv = 1'b0;
    qv = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic pair(input string name, input int i0, input int q0, input int i1, input int q1,
                      input bit mismatch, input longint req);
    reset_mid();
    strobes  = 0;
    last_out = 12345;
    send(i0, q0, 1, 1);
    if (mismatch) send(5, 5, 1, 0);
    send(i1, q1, 1, 1);
    idle(5);
    check(name, last_out, req);
    check({name, "_strobes"}, strobes, PAIR_STROBES);
  endtask

  initial begin
    real ph, fr;
    int  r;
    model_reset();
    #1;
    check("init_o_valid", longint'(o_valid), 0);
    check("init_o_data", longint'(o_data), 0);
    step();
    step();
    rst_n = 1'b1;

    // Reset with samples in flight: nothing may emerge afterwards.
    strobes = 0;
    send(1000, 0, 1, 1);
    send(0, 1000, 1, 1);
    reset_mid();
    idle(6);
    check("flush_strobes", strobes, 0);

    pair("pos_rot", 1000, 0, 0, 1000, 0, 1000000);
    pair("neg_rot", 0, 1000, 1000, 0, 0, -1000000);
    pair("extreme", -32768, -32768, -32768, 32767, 0, -2147450880);
    pair("mismatch", 1000, 0, 0, 1000, 1, 1000000);

    // Chirp at one accept every 20 clocks.
    reset_mid();
    strobes = 0;
    ph = 0.0;
    fr = 0.01;
    for (int n = 0; n < 60; n++) begin
      send($rtoi(20000.0 * $cos(ph)), $rtoi(20000.0 * $sin(ph)), 1, 1);
      idle(19);
      ph = ph + fr;
      fr = fr + 0.02;
    end
    check("chirp_strobes", strobes, PAIR_STROBES == 2 ? 60 : 59);

    // Continuous random traffic with occasional mismatched valids and a mid-stream reset.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) reset_mid();
      r = $urandom_range(0, 9);
      send(int'($urandom()), int'($urandom()), r != 1, r != 2);
    end
    idle(5);
    check("drain_empty", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
